sprite_motion_ctrl: RTL and testbench

Per-frame position scheduler for one on-screen sprite in the 640x480 @ 60 Hz VGA pipeline. It samples debounced direction buttons once per frame at the start of vertical blank, moves the sprite by a fixed step and clamps it to a bounding box. It drives the X/Y origin consumed by the sprite ROM-address/on-flag block. Positions change only during blanking, so the sprite never tears mid-frame.

---
 rtl/sprite_motion_ctrl_pkg.sv | 19 +
 rtl/sprite_motion_ctrl_if.sv | 23 ++
 rtl/sprite_motion_ctrl.sv | 129 ++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared screen constants, bus widths and FSM encoding for the per-frame sprite motion scheduler.
package sprite_motion_ctrl_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int YY_W  = 10;
  localparam int BTN_W = 4;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIV    = 2'd1,
    ST_CALC   = 2'd2,
    ST_COMMIT = 2'd3
  } motion_state_t;

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Bundle between the VGA timing/button side and the sprite motion scheduler.
interface sprite_motion_ctrl_if;
  import sprite_motion_ctrl_pkg::*;

  logic [YY_W-1:0]  i_yy;
  logic [BTN_W-1:0] i_btn;
  logic             i_freeze;
  logic             i_load;
  logic [X_W-1:0]   o_x;
  logic [Y_W-1:0]   o_y;
  logic             o_upd;

  modport master (
    output i_yy, i_btn, i_freeze, i_load,
    input  o_x, o_y, o_upd
  );

  modport slave (
    input  i_yy, i_btn, i_freeze, i_load,
    output o_x, o_y, o_upd
  );

endinterface

// File: rtl/sprite_motion_ctrl.sv
// Samples the direction buttons once per (divided) frame at the start of vblank and
// commits a clamped sprite origin, so the position only ever changes during blanking.
module sprite_motion_ctrl #(
  parameter int V_ACTIVE  = sprite_motion_ctrl_pkg::V_ACTIVE,
  parameter int SPRITE_W  = 26,
  parameter int SPRITE_H  = 37,
  parameter int X_INIT    = 300,
  parameter int Y_INIT    = 100,
  parameter int STEP      = 2,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = sprite_motion_ctrl_pkg::H_ACTIVE,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = sprite_motion_ctrl_pkg::V_ACTIVE,
  parameter int FRAME_DIV = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  sprite_motion_ctrl_if.slave  sp_bus
);
  import sprite_motion_ctrl_pkg::*;

  localparam logic [YY_W-1:0] LP_VB       = YY_W'(V_ACTIVE);
  localparam logic [3:0]      LP_DIV_LAST = 4'(FRAME_DIV - 1);
  localparam logic [10:0]     LP_STEP11   = 11'(STEP);
  localparam logic [10:0]     LP_X_LO_TH  = 11'(X_MIN + STEP);
  localparam logic [10:0]     LP_X_HI_TH  = 11'(X_MAX - SPRITE_W);
  localparam logic [10:0]     LP_Y_LO_TH  = 11'(Y_MIN + STEP);
  localparam logic [10:0]     LP_Y_HI_TH  = 11'(Y_MAX - SPRITE_H);
  localparam logic [X_W-1:0]  LP_X_INIT   = X_W'(X_INIT);
  localparam logic [X_W-1:0]  LP_X_LO     = X_W'(X_MIN);
  localparam logic [X_W-1:0]  LP_X_HI     = X_W'(X_MAX - SPRITE_W);
  localparam logic [X_W-1:0]  LP_X_STEP   = X_W'(STEP);
  localparam logic [Y_W-1:0]  LP_Y_INIT   = Y_W'(Y_INIT);
  localparam logic [Y_W-1:0]  LP_Y_LO     = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0]  LP_Y_HI     = Y_W'(Y_MAX - SPRITE_H);
  localparam logic [Y_W-1:0]  LP_Y_STEP   = Y_W'(STEP);

  motion_state_t   r_state;
  motion_state_t   w_nextState;
  logic [YY_W-1:0] r_yyQ;
  logic [3:0]      r_div;
  logic            r_loadPend;
  logic [X_W-1:0]  r_x;
  logic [Y_W-1:0]  r_y;
  logic [X_W-1:0]  r_nx;
  logic [Y_W-1:0]  r_ny;
  logic            r_upd;
  logic            w_vbStart;
  logic [X_W-1:0]  w_nx;
  logic [Y_W-1:0]  w_ny;

  assign w_vbStart = (sp_bus.i_yy == LP_VB) && (r_yyQ != LP_VB);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_vbStart) w_nextState = ST_DIV;
      ST_DIV:    w_nextState = (r_div == LP_DIV_LAST) ? ST_CALC : ST_IDLE;
      ST_CALC:   w_nextState = ST_COMMIT;
      ST_COMMIT: w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Opposing buttons cancel per axis; compares run one bit wider so the clamp sees overflow.
  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    if (!sp_bus.i_freeze) begin
      if (sp_bus.i_btn[1] && !sp_bus.i_btn[0]) begin
        w_nx = ({1'b0, r_x} < LP_X_LO_TH) ? LP_X_LO : r_x - LP_X_STEP;
      end else if (sp_bus.i_btn[0] && !sp_bus.i_btn[1]) begin
        w_nx = (({1'b0, r_x} + LP_STEP11) > LP_X_HI_TH) ? LP_X_HI : r_x + LP_X_STEP;
      end
      if (sp_bus.i_btn[3] && !sp_bus.i_btn[2]) begin
        w_ny = ({2'b00, r_y} < LP_Y_LO_TH) ? LP_Y_LO : r_y - LP_Y_STEP;
      end else if (sp_bus.i_btn[2] && !sp_bus.i_btn[3]) begin
        w_ny = (({2'b00, r_y} + LP_STEP11) > LP_Y_HI_TH) ? LP_Y_HI : r_y + LP_Y_STEP;
      end
    end
  end

  // Recentre is resolved at COMMIT so a load arriving during CALC is still honoured.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_yyQ      <= '0;
      r_div      <= '0;
      r_loadPend <= 1'b0;
      r_x        <= LP_X_INIT;
      r_y        <= LP_Y_INIT;
      r_nx       <= LP_X_INIT;
      r_ny       <= LP_Y_INIT;
      r_upd      <= 1'b0;
    end else begin
      r_yyQ <= sp_bus.i_yy;
      r_upd <= 1'b0;
      if (r_state == ST_COMMIT) begin
        r_loadPend <= sp_bus.i_load;
      end else if (sp_bus.i_load) begin
        r_loadPend <= 1'b1;
      end
      if (r_state == ST_DIV) begin
        r_div <= (r_div == LP_DIV_LAST) ? 4'd0 : r_div + 4'd1;
      end
      if (r_state == ST_CALC) begin
        r_nx <= w_nx;
        r_ny <= w_ny;
      end
      if (r_state == ST_COMMIT) begin
        r_x   <= r_loadPend ? LP_X_INIT : r_nx;
        r_y   <= r_loadPend ? LP_Y_INIT : r_ny;
        r_upd <= 1'b1;
      end
    end
  end

  assign sp_bus.o_x   = r_x;
  assign sp_bus.o_y   = r_y;
  assign sp_bus.o_upd = r_upd;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench: two schedulers (every frame, and every third frame from a corner start)
// driven with shortened VGA frames and compared against a per-frame position model.
`timescale 1ns/1ps
module tb_sprite_motion_ctrl;

  localparam int STEP  = 2;
  localparam int X_HI  = 640 - 26;
  localparam int Y_HI  = 480 - 37;
  localparam int Y_INI = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sprite_motion_ctrl_if busA();
  sprite_motion_ctrl_if busB();

  sprite_motion_ctrl #(.FRAME_DIV(1)) u_dutA (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .sp_bus  (busA.slave)
  );

  sprite_motion_ctrl #(.FRAME_DIV(3), .X_INIT(5)) u_dutB (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .sp_bus  (busB.slave)
  );

  int total = 0;
  int bad   = 0;
  int xInit[2];
  int frameDiv[2];
  int mx[2], my[2], mdiv[2];
  bit mpend[2];
  int updCnt[2];
  logic [9:0] sx[2];
  logic [8:0] sy[2];
  logic       su[2];

  function automatic int moveAxis(input int p, input logic dec, input logic inc, input int lo, input int hi);
    if (dec && !inc) return (p - STEP < lo) ? lo : p - STEP;
    if (inc && !dec) return (p + STEP > hi) ? hi : p + STEP;
    return p;
  endfunction

  task automatic drive(input logic [9:0] yy, input logic [3:0] btn, input logic frz, input logic ld);
    busA.i_yy = yy;  busA.i_btn = btn;  busA.i_freeze = frz;  busA.i_load = ld;
    busB.i_yy = yy;  busB.i_btn = btn;  busB.i_freeze = frz;  busB.i_load = ld;
  endtask

  task automatic step(input logic [9:0] yy, input logic [3:0] btn, input logic frz, input logic ld);
    @(posedge clk);
    #1;
    drive(yy, btn, frz, ld);
    @(negedge clk);
    sx[0] = busA.o_x;  sy[0] = busA.o_y;  su[0] = busA.o_upd;
    sx[1] = busB.o_x;  sy[1] = busB.o_y;  su[1] = busB.o_upd;
    for (int d = 0; d < 2; d++) if (su[d] === 1'b1) updCnt[d]++;
  endtask

  task automatic assert_reset(input logic [3:0] btn);
    @(negedge clk);
    drive(10'd200, btn, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      mx[d] = xInit[d];  my[d] = Y_INI;  mdiv[d] = 0;  mpend[d] = 1'b0;
    end
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_reset(input logic [3:0] btn);
    assert_reset(btn);
    release_reset();
  endtask

  // One shortened frame: visible lines with optional noise, then vblank entry held `hold` cycles.
  task automatic run_frame(input logic [3:0] btnVb, input logic frzVb, input logic loadPre,
                           input logic loadCommit, input logic toggle, input int hold);
    int preLen;
    bit commit[2];
    int nx[2], ny[2];
    int ex, ey;
    logic eu;
    logic [9:0] yyv;
    preLen = 3 + $urandom_range(0, 3);
    for (int k = 0; k < preLen; k++) begin
      step(10'($urandom_range(0, 479)),
           toggle ? 4'($urandom_range(0, 15)) : btnVb,
           toggle ? 1'($urandom_range(0, 1)) : frzVb,
           loadPre && (k == 1));
      if (loadPre && (k == 1)) begin
        mpend[0] = 1'b1;  mpend[1] = 1'b1;
      end
      for (int d = 0; d < 2; d++) begin
        total++;
        if (su[d] !== 1'b0) begin
          bad++;
          $display("[TB] FAIL visible_upd dut%0d got=%b want=0", d, su[d]);
        end
        total++;
        if (sx[d] !== 10'(mx[d]) || sy[d] !== 9'(my[d])) begin
          bad++;
          $display("[TB] FAIL visible_pos dut%0d got=(%0d,%0d) want=(%0d,%0d)", d, sx[d], sy[d], mx[d], my[d]);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      mdiv[d]++;
      commit[d] = (mdiv[d] == frameDiv[d]);
      nx[d] = mx[d];
      ny[d] = my[d];
      if (commit[d]) begin
        mdiv[d] = 0;
        if (mpend[d]) begin
          nx[d] = xInit[d];
          ny[d] = Y_INI;
        end else if (!frzVb) begin
          nx[d] = moveAxis(mx[d], btnVb[1], btnVb[0], 0, X_HI);
          ny[d] = moveAxis(my[d], btnVb[3], btnVb[2], 0, Y_HI);
        end
        mpend[d] = 1'b0;
      end
    end
    for (int off = 0; off < hold + 6; off++) begin
      yyv = (off < hold) ? 10'd480 : 10'(480 + off - hold + 1);
      step(yyv, btnVb, frzVb, loadCommit && (off == 3));
      for (int d = 0; d < 2; d++) begin
        eu = commit[d] && (off == 4);
        ex = (commit[d] && off >= 4) ? nx[d] : mx[d];
        ey = (commit[d] && off >= 4) ? ny[d] : my[d];
        total++;
        if (su[d] !== eu) begin
          bad++;
          $display("[TB] FAIL vblank_upd dut%0d off=%0d got=%b want=%b", d, off, su[d], eu);
        end
        total++;
        if (sx[d] !== 10'(ex) || sy[d] !== 9'(ey)) begin
          bad++;
          $display("[TB] FAIL vblank_pos dut%0d off=%0d got=(%0d,%0d) want=(%0d,%0d)", d, off, sx[d], sy[d], ex, ey);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (commit[d]) begin
        mx[d] = nx[d];
        my[d] = ny[d];
      end
      if (loadCommit) mpend[d] = 1'b1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) step(10'(100 + i), 4'b0001, 1'b0, 1'b0);
    assert_reset(4'b0001);
    total++;
    if (busA.o_x !== 10'd300 || busA.o_y !== 9'd100) begin
      bad++;
      $display("[TB] FAIL reset_posA got=(%0d,%0d) want=(300,100)", busA.o_x, busA.o_y);
    end
    total++;
    if (busA.o_upd !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_updA got=%b want=0", busA.o_upd);
    end
    total++;
    if (busB.o_x !== 10'd5 || busB.o_y !== 9'd100) begin
      bad++;
      $display("[TB] FAIL reset_posB got=(%0d,%0d) want=(5,100)", busB.o_x, busB.o_y);
    end
    total++;
    if (busB.o_upd !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_updB got=%b want=0", busB.o_upd);
    end
    release_reset();
    run_frame(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    total++;
    if (sx[0] !== 10'd302 || sx[1] !== 10'd5) begin
      bad++;
      $display("[TB] FAIL first_frame got=(%0d,%0d) want=(302,5)", sx[0], sx[1]);
    end
  endtask

  task automatic test_right_hold();
    int c0, c1;
    do_reset(4'b0001);
    c0 = updCnt[0];  c1 = updCnt[1];
    for (int f = 0; f < 10; f++) run_frame(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, $urandom_range(1, 3));
    total++;
    if (sx[0] !== 10'd320 || sy[0] !== 9'd100) begin
      bad++;
      $display("[TB] FAIL right10_posA got=(%0d,%0d) want=(320,100)", sx[0], sy[0]);
    end
    total++;
    if (updCnt[0] - c0 != 10 || updCnt[1] - c1 != 3) begin
      bad++;
      $display("[TB] FAIL right10_pulses got=(%0d,%0d) want=(10,3)", updCnt[0] - c0, updCnt[1] - c1);
    end
    total++;
    if (sx[1] !== 10'd11) begin
      bad++;
      $display("[TB] FAIL right10_posB got=%0d want=11", sx[1]);
    end
  endtask

  task automatic test_lr_down();
    do_reset(4'b0111);
    for (int f = 0; f < 5; f++) run_frame(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    total++;
    if (sx[0] !== 10'd300 || sy[0] !== 9'd110) begin
      bad++;
      $display("[TB] FAIL lr_down_posA got=(%0d,%0d) want=(300,110)", sx[0], sy[0]);
    end
    total++;
    if (sx[1] !== 10'd5 || sy[1] !== 9'd102) begin
      bad++;
      $display("[TB] FAIL lr_down_posB got=(%0d,%0d) want=(5,102)", sx[1], sy[1]);
    end
  endtask

  task automatic test_walls();
    int c0;
    int wantX[3] = '{612, 614, 614};
    do_reset(4'b0001);
    for (int f = 0; f < 155; f++) run_frame(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    total++;
    if (sx[0] !== 10'd610) begin
      bad++;
      $display("[TB] FAIL wall_approach got=%0d want=610", sx[0]);
    end
    c0 = updCnt[0];
    for (int f = 0; f < 3; f++) begin
      run_frame(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      total++;
      if (sx[0] !== 10'(wantX[f])) begin
        bad++;
        $display("[TB] FAIL right_wall f=%0d got=%0d want=%0d", f, sx[0], wantX[f]);
      end
    end
    total++;
    if (updCnt[0] - c0 != 3) begin
      bad++;
      $display("[TB] FAIL wall_pulses got=%0d want=3", updCnt[0] - c0);
    end
    do_reset(4'b0010);
    for (int f = 0; f < 6; f++) run_frame(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    total++;
    if (sx[1] !== 10'd1) begin
      bad++;
      $display("[TB] FAIL left_near got=%0d want=1", sx[1]);
    end
    for (int f = 0; f < 6; f++) run_frame(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    total++;
    if (sx[1] !== 10'd0) begin
      bad++;
      $display("[TB] FAIL left_wall got=%0d want=0", sx[1]);
    end
  endtask

  task automatic test_frame_div();
    int c1;
    do_reset(4'b1000);
    c1 = updCnt[1];
    for (int f = 0; f < 9; f++) run_frame(4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, $urandom_range(1, 3));
    total++;
    if (sy[1] !== 9'd94 || updCnt[1] - c1 != 3) begin
      bad++;
      $display("[TB] FAIL div3_up got=(y=%0d,n=%0d) want=(y=94,n=3)", sy[1], updCnt[1] - c1);
    end
    total++;
    if (sy[0] !== 9'd82) begin
      bad++;
      $display("[TB] FAIL div1_up got=%0d want=82", sy[0]);
    end
  endtask

  task automatic test_load_freeze();
    do_reset(4'b0001);
    for (int f = 0; f < 50; f++) run_frame(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    total++;
    if (sx[0] !== 10'd400) begin
      bad++;
      $display("[TB] FAIL load_setup got=%0d want=400", sx[0]);
    end
    run_frame(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    total++;
    if (sx[0] !== 10'd300 || sy[0] !== 9'd100) begin
      bad++;
      $display("[TB] FAIL load_frozen got=(%0d,%0d) want=(300,100)", sx[0], sy[0]);
    end
    run_frame(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    total++;
    if (sx[0] !== 10'd300) begin
      bad++;
      $display("[TB] FAIL freeze_hold got=%0d want=300", sx[0]);
    end
    run_frame(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    total++;
    if (sx[0] !== 10'd302) begin
      bad++;
      $display("[TB] FAIL load_at_commit got=%0d want=302", sx[0]);
    end
    run_frame(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    total++;
    if (sx[0] !== 10'd300) begin
      bad++;
      $display("[TB] FAIL load_deferred got=%0d want=300", sx[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(4'b0000);
    for (int f = 0; f < 40; f++) begin
      run_frame(4'($urandom_range(0, 15)),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0,
                1'($urandom_range(0, 1)),
                $urandom_range(1, 4));
    end
  endtask

  initial begin
    xInit[0] = 300;  xInit[1] = 5;
    frameDiv[0] = 1; frameDiv[1] = 3;
    updCnt[0] = 0;   updCnt[1] = 0;
    drive(10'd0, 4'b0000, 1'b0, 1'b0);
    test_reset();
    test_right_hold();
    test_lr_down();
    test_walls();
    test_frame_div();
    test_load_freeze();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
